// File: rtl/sigma_16p_if.sv
// ---------------------------------------------------------------------------
// sigma_16p_if -- sample/result bundle for the 16-sample block summer.
//
//   data_in  [7:0]  sign-magnitude sample (bit7 = sign, bits[6:0] = magnitude)
//   syn_in          sample strobe; each rising edge marks one valid sample
//   data_out [11:0] two's-complement sum of the last completed 16-sample block
//   syn_out         one-cycle pulse accompanying every new data_out value
//
// master: the sample source (drives data_in/syn_in, observes the result)
// slave : the summer itself
// ---------------------------------------------------------------------------
interface sigma_16p_if;
  logic [7:0]  data_in;
  logic        syn_in;
  logic [11:0] data_out;
  logic        syn_out;

  modport master (output data_in, syn_in, input  data_out, syn_out);
  modport slave  (input  data_in, syn_in, output data_out, syn_out);
endinterface : sigma_16p_if

// File: rtl/sigma_16p.sv
// ---------------------------------------------------------------------------
// sigma_16p -- sums blocks of 16 sign-magnitude samples.
//
// A sample is accepted on the clock where syn_in is high and was low on the
// previous clock. Samples are converted to 12-bit two's complement and added
// to a running partial sum; the 16th sample of a block completes the sum,
// which is presented on data_out together with a one-clock syn_out pulse.
// data_out holds until the next block completes.
//
// Ports:
//   clk  in  single clock, rising edge
//   res  in  asynchronous active-low reset; clears all state
//   bus  slave modport of sigma_16p_if (data_in, syn_in, data_out, syn_out)
// ---------------------------------------------------------------------------
module sigma_16p (
  input  logic       clk,
  input  logic       res,
  sigma_16p_if.slave bus
);

  logic        syn_d;
  logic        syn_edge;
  logic [3:0]  cnt;
  logic [11:0] acc;
  logic [11:0] value;
  logic [11:0] data_out_q;
  logic        syn_out_q;

  // Resetting syn_d to 0 means a strobe already high when reset is released
  // is taken as a fresh sample on the first clock.
  assign syn_edge = bus.syn_in & ~syn_d;

  // Sign-magnitude to two's complement. Negating a zero magnitude yields
  // zero, so 8'h80 needs no special case.
  // NOTE: every signal written in always_comb gets an unconditional default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    value = {5'b0, bus.data_in[6:0]};
    if (bus.data_in[7]) begin
      value = -value;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      syn_d      <= 1'b0;
      cnt        <= 4'd0;
      acc        <= 12'd0;
      data_out_q <= 12'd0;
      syn_out_q  <= 1'b0;
    end else begin
      syn_d     <= bus.syn_in;
      syn_out_q <= 1'b0;
      if (syn_edge) begin
        if (cnt == 4'd15) begin
          // The 16th sample closes the block; its value is part of the result.
          data_out_q <= acc + value;
          syn_out_q  <= 1'b1;
          acc        <= 12'd0;
          cnt        <= 4'd0;
        end else begin
          acc <= acc + value;
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.syn_out  = syn_out_q;

endmodule : sigma_16p

// File: tb/tb_sigma_16p.sv
// ---------------------------------------------------------------------------
// tb_sigma_16p -- self-checking bench for sigma_16p.
//
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge. The reference model keeps the accepted samples of the current block
// as signed integers in a queue and sums them when the 16th arrives.
// ---------------------------------------------------------------------------
module tb_sigma_16p;

  logic clk;
  logic res;

  sigma_16p_if bus ();

  sigma_16p dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state
  int          blk_q[$];
  logic [11:0] last_out = 12'h000;
  logic [11:0] exp_out  = 12'h000;
  logic        pend     = 1'b0;

  task automatic check(input string tag, input logic [11:0] actual,
                       input logic [11:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 12'h%03h, expected 12'h%03h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  function automatic int sm_value(input logic [7:0] b);
    int mag;
    mag = int'(b[6:0]);
    return b[7] ? -mag : mag;
  endfunction

  // Record one accepted sample; flag a pending result when a block fills.
  task automatic model_push(input logic [7:0] b);
    int sum;
    blk_q.push_back(sm_value(b));
    if (blk_q.size() == 16) begin
      sum = 0;
      foreach (blk_q[i]) sum += blk_q[i];
      exp_out = 12'(sum);
      pend    = 1'b1;
      blk_q.delete();
    end
  endtask

  // Called on the falling edge right after the capturing rising edge.
  task automatic check_capture();
    check("syn_out_capture", {11'b0, bus.syn_out}, {11'b0, pend});
    if (pend) begin
      check("data_out_block", bus.data_out, exp_out);
      last_out = exp_out;
      pend     = 1'b0;
    end else begin
      check("data_out_hold_cap", bus.data_out, last_out);
    end
  endtask

  // Idle clocks: no new result may appear. data_in is scrambled while the
  // strobe is low to show it is ignored outside a capture.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("syn_out_idle", {11'b0, bus.syn_out}, 12'h000);
      check("data_out_hold", bus.data_out, last_out);
      if (!bus.syn_in) bus.data_in = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hi, input int lo);
    @(negedge clk);
    bus.data_in = b;
    bus.syn_in  = 1'b1;
    model_push(b);
    @(negedge clk);
    check_capture();
    idle(hi - 1);
    bus.syn_in = 1'b0;
    idle(lo);
  endtask

  task automatic send_n(input int n, input logic [7:0] b,
                        input int hi, input int lo);
    for (int i = 0; i < n; i++) send(b, hi, lo);
  endtask

  initial begin
    res         = 1'b0;
    bus.syn_in  = 1'b0;
    bus.data_in = 8'h00;

    // Reset state, then release at 17 ns.
    #12;
    check("rst_data_out", bus.data_out, 12'h000);
    check("rst_syn_out", {11'b0, bus.syn_out}, 12'h000);
    #5 res = 1'b1;

    // Constant +2, strobe toggling every 100 ns -> 32.
    send_n(16, 8'h02, 10, 10);
    check("const_pos_value", last_out, 12'h020);

    // Negative, negative zero, full scale both signs.
    send_n(16, 8'h81, 2, 2);
    send_n(16, 8'h80, 1, 1);
    send_n(16, 8'h7F, 1, 2);
    send_n(16, 8'hFF, 3, 1);

    // Mixed block: 8 x +5 and 8 x -3 -> +16.
    send_n(8, 8'h05, 1, 1);
    send_n(8, 8'h83, 1, 1);

    // Reset mid-block after 5 samples; outputs clear asynchronously.
    send_n(5, 8'h01, 1, 1);
    @(negedge clk);
    res = 1'b0;
    #1;
    check("async_rst_data_out", bus.data_out, 12'h000);
    check("async_rst_syn_out", {11'b0, bus.syn_out}, 12'h000);
    blk_q.delete();
    last_out = 12'h000;
    pend     = 1'b0;
    // Strobe activity during reset is ignored.
    bus.syn_in = 1'b1;
    idle(2);
    bus.syn_in = 1'b0;
    idle(2);
    // Strobe already high at release counts as the first sample, and being
    // held for 50 clocks still counts once.
    bus.data_in = 8'h01;
    bus.syn_in  = 1'b1;
    model_push(8'h01);
    idle(2);
    res = 1'b1;
    @(negedge clk);
    check_capture();
    idle(49);
    bus.syn_in = 1'b0;
    idle(2);
    send_n(15, 8'h01, 1, 1);
    check("post_reset_value", last_out, 12'h010);

    // Randomised blocks with random strobe shapes.
    for (int blk = 0; blk < 12; blk++) begin
      for (int s = 0; s < 16; s++) begin
        send(8'($urandom), int'($urandom_range(1, 4)),
             int'($urandom_range(1, 4)));
      end
    end

    // A partial trailing block must not produce a result.
    send_n(7, 8'($urandom), 1, 1);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sigma_16p
